mem_port_arbiter: RTL and testbench

Arbitrates the single-ported `memory_ram` between the instruction-fetch requester and the load/store (MEM-stage) requester of the 16-bit pipeline. Each cycle it grants at most one requester, drives the RAM, and returns registered read data, error, and write-completion status one cycle later. Load/store has priority, and a starvation counter guarantees forward progress for fetch. It also generates per-requester stall signals and a sticky error record for the exception logic.

---
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single-ported memory_ram between instruction fetch (if_*) and
//   load/store (ls_*). Load/store wins conflicts unless fetch has lost
//   STARVE_LIMIT consecutive conflicts. Responses, error flags and the store
//   completion strobe are registered and appear one cycle after the grant.
//
// Ports
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_if_req/i_if_addr       fetch read request (held until granted)
//   o_if_gnt/o_if_stall      fetch grant / stall (combinational)
//   o_if_rsp_*               fetch response (registered)
//   i_ls_req/wr/addr/wdata   load/store request (held until granted)
//   o_ls_gnt/o_ls_stall      load/store grant / stall (combinational)
//   o_ls_rsp_*, o_ls_wr_done load/store response (registered)
//   o_mem_*, i_mem_*         RAM interface (read data/err combinational)
//   o_err_sticky/o_err_addr  first-fault record, cleared by i_err_clr
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter int CNT_W        = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_if_req,
    input  logic [15:0] i_if_addr,
    output logic        o_if_gnt,
    output logic        o_if_stall,
    output logic        o_if_rsp_valid,
    output logic [15:0] o_if_rsp_data,
    output logic        o_if_rsp_err,
    input  logic        i_ls_req,
    input  logic        i_ls_wr,
    input  logic [15:0] i_ls_addr,
    input  logic [15:0] i_ls_wdata,
    output logic        o_ls_gnt,
    output logic        o_ls_stall,
    output logic        o_ls_rsp_valid,
    output logic [15:0] o_ls_rsp_data,
    output logic        o_ls_rsp_err,
    output logic        o_ls_wr_done,
    output logic        o_mem_enable,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_wr,
    output logic [15:0] o_mem_data_in,
    input  logic [15:0] i_mem_data_out,
    input  logic        i_mem_err,
    output logic        o_err_sticky,
    output logic [15:0] o_err_addr,
    input  logic        i_err_clr
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_if_rsp_valid, r_ls_rsp_valid;
    logic [15:0]      r_if_rsp_data, r_ls_rsp_data;
    logic             r_if_rsp_err, r_ls_rsp_err, r_ls_wr_done;
    logic             r_err_sticky;
    logic [15:0]      r_err_addr;

    logic             w_if_gnt, w_ls_gnt, w_any_gnt, w_conflict, w_fault;
    logic [15:0]      w_addr;

    // Fetch takes the port when alone, or on a conflict once it has starved.
    always_comb begin
        w_conflict = i_if_req & i_ls_req;
        w_if_gnt   = i_if_req & (~i_ls_req | (r_starve_cnt == LIMIT));
        w_ls_gnt   = i_ls_req & ~w_if_gnt;
        w_any_gnt  = w_if_gnt | w_ls_gnt;
        w_addr     = w_if_gnt ? i_if_addr : (w_ls_gnt ? i_ls_addr : '0);
        w_fault    = w_any_gnt & i_mem_err;
    end

    assign o_if_gnt      = w_if_gnt;
    assign o_ls_gnt      = w_ls_gnt;
    assign o_if_stall    = i_if_req & ~w_if_gnt;
    assign o_ls_stall    = i_ls_req & ~w_ls_gnt;
    assign o_mem_enable  = w_any_gnt;
    assign o_mem_addr    = w_addr;
    assign o_mem_wr      = w_ls_gnt & i_ls_wr;
    assign o_mem_data_in = (w_ls_gnt & i_ls_wr) ? i_ls_wdata : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_starve_cnt   <= '0;
            r_if_rsp_valid <= 1'b0;
            r_ls_rsp_valid <= 1'b0;
            r_if_rsp_data  <= '0;
            r_ls_rsp_data  <= '0;
            r_if_rsp_err   <= 1'b0;
            r_ls_rsp_err   <= 1'b0;
            r_ls_wr_done   <= 1'b0;
            r_err_sticky   <= 1'b0;
            r_err_addr     <= '0;
        end else begin
            if (w_if_gnt || !i_if_req)
                r_starve_cnt <= '0;
            else if (w_conflict && w_ls_gnt && r_starve_cnt != LIMIT)
                r_starve_cnt <= r_starve_cnt + 1'b1;

            r_if_rsp_valid <= w_if_gnt;
            r_ls_rsp_valid <= w_ls_gnt;
            r_ls_wr_done   <= w_ls_gnt & i_ls_wr & ~i_mem_err;
            if (w_if_gnt) begin
                r_if_rsp_data <= i_mem_data_out;
                r_if_rsp_err  <= i_mem_err;
            end
            if (w_ls_gnt) begin
                r_ls_rsp_data <= i_ls_wr ? '0 : i_mem_data_out;
                r_ls_rsp_err  <= i_mem_err;
            end

            // A fault in the clear cycle restarts the record with its address.
            if (w_fault) begin
                r_err_sticky <= 1'b1;
                if (!r_err_sticky || i_err_clr)
                    r_err_addr <= w_addr;
            end else if (i_err_clr) begin
                r_err_sticky <= 1'b0;
                r_err_addr   <= '0;
            end
        end
    end

    assign o_if_rsp_valid = r_if_rsp_valid;
    assign o_if_rsp_data  = r_if_rsp_data;
    assign o_if_rsp_err   = r_if_rsp_err;
    assign o_ls_rsp_valid = r_ls_rsp_valid;
    assign o_ls_rsp_data  = r_ls_rsp_data;
    assign o_ls_rsp_err   = r_ls_rsp_err;
    assign o_ls_wr_done   = r_ls_wr_done;
    assign o_err_sticky   = r_err_sticky;
    assign o_err_addr     = r_err_addr;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Drives the arbiter against a behavioural RAM and predicts every output
//   from a reference model of the arbitration, response and error rules.
module tb_mem_port_arbiter;

    localparam int LIM = 3;

    logic        clk = 1'b0;
    logic        rst, if_req, ls_req, ls_wr, mem_err, err_clr;
    logic [15:0] if_addr, ls_addr, ls_wdata;
    logic        if_gnt, if_stall, if_rsp_valid, if_rsp_err;
    logic        ls_gnt, ls_stall, ls_rsp_valid, ls_rsp_err, ls_wr_done;
    logic        mem_enable, mem_wr, err_sticky;
    logic [15:0] if_rsp_data, ls_rsp_data, mem_addr, mem_data_in, mem_data_out, err_addr;

    logic [15:0] ram [0:255];

    int checks = 0;
    int failures = 0;

    // Reference model state
    int          lost;          // consecutive conflicts fetch has lost
    logic        eg_if, eg_ls;  // expected grants for the current cycle
    logic        m_if_valid, m_if_err, m_ls_valid, m_ls_err, m_wr_done, m_sticky;
    logic [15:0] m_if_data, m_ls_data, m_eaddr;

    mem_port_arbiter #(.STARVE_LIMIT(LIM), .CNT_W(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt), .o_if_stall(if_stall),
        .o_if_rsp_valid(if_rsp_valid), .o_if_rsp_data(if_rsp_data), .o_if_rsp_err(if_rsp_err),
        .i_ls_req(ls_req), .i_ls_wr(ls_wr), .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
        .o_ls_gnt(ls_gnt), .o_ls_stall(ls_stall), .o_ls_rsp_valid(ls_rsp_valid),
        .o_ls_rsp_data(ls_rsp_data), .o_ls_rsp_err(ls_rsp_err), .o_ls_wr_done(ls_wr_done),
        .o_mem_enable(mem_enable), .o_mem_addr(mem_addr), .o_mem_wr(mem_wr),
        .o_mem_data_in(mem_data_in), .i_mem_data_out(mem_data_out), .i_mem_err(mem_err),
        .o_err_sticky(err_sticky), .o_err_addr(err_addr), .i_err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM: combinational read, write at the edge.
    assign mem_data_out = ram[mem_addr[7:0]];
    always @(posedge clk) if (mem_enable && mem_wr) ram[mem_addr[7:0]] <= mem_data_in;

    logic [53:0] dvec;
    assign dvec = {if_rsp_valid, if_rsp_data, if_rsp_err, ls_rsp_valid, ls_rsp_data,
                   ls_rsp_err, ls_wr_done, err_sticky, err_addr};
    logic [37:0] dgnt;
    assign dgnt = {if_gnt, ls_gnt, if_stall, ls_stall, mem_enable, mem_wr, mem_addr, mem_data_in};

    function automatic logic [53:0] mvec();
        return {m_if_valid, m_if_data, m_if_err, m_ls_valid, m_ls_data,
                m_ls_err, m_wr_done, m_sticky, m_eaddr};
    endfunction

    function automatic logic [37:0] mgnt();
        logic [15:0] a, d;
        a = eg_if ? if_addr : (eg_ls ? ls_addr : 16'h0);
        d = (eg_ls && ls_wr) ? ls_wdata : 16'h0;
        return {eg_if, eg_ls, if_req & ~eg_if, ls_req & ~eg_ls, eg_if | eg_ls,
                eg_ls & ls_wr, a, d};
    endfunction

    // Apply one cycle of inputs after the falling edge and predict the grant.
    task automatic drive(input logic ir, input logic [15:0] ia, input logic lr, lw,
                         input logic [15:0] la, lwd, input logic e, c, r);
        @(negedge clk);
        if_req = ir; if_addr = ia; ls_req = lr; ls_wr = lw; ls_addr = la; ls_wdata = lwd;
        mem_err = e; err_clr = c; rst = r;
        #1;
        eg_if = if_req && (!ls_req || lost >= LIM);
        eg_ls = ls_req && !eg_if;
    endtask

    // Advance the model across the rising edge, then settle.
    task automatic tick();
        logic [15:0] ga, rd;
        ga = eg_if ? if_addr : (eg_ls ? ls_addr : 16'h0);
        rd = ram[ga[7:0]];
        if (rst) begin
            lost = 0;
            {m_if_valid, m_if_err, m_ls_valid, m_ls_err, m_wr_done, m_sticky} = '0;
            m_if_data = '0; m_ls_data = '0; m_eaddr = '0;
        end else begin
            if (eg_if || !if_req) lost = 0;
            else if (if_req && ls_req) lost = (lost + 1 > LIM) ? LIM : lost + 1;
            m_if_valid = eg_if;
            m_ls_valid = eg_ls;
            m_wr_done  = eg_ls && ls_wr && !mem_err;
            if (eg_if) begin m_if_data = rd; m_if_err = mem_err; end
            if (eg_ls) begin m_ls_data = ls_wr ? 16'h0 : rd; m_ls_err = mem_err; end
            if ((eg_if || eg_ls) && mem_err) begin
                if (!m_sticky || err_clr) m_eaddr = ga;
                m_sticky = 1'b1;
            end else if (err_clr) begin
                m_sticky = 1'b0; m_eaddr = '0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        checks++;
        if (dvec !== 54'h0) begin
            failures++; $display("FAIL reset_regs got=%h exp=0", dvec);
        end
        drive(0, 16'h0033, 0, 0, 16'h0044, 16'h5555, 0, 0, 0);
        checks++;
        if (dgnt !== 38'h0) begin
            failures++; $display("FAIL idle_no_grant got=%h exp=0", dgnt);
        end
        tick();
    endtask

    task automatic test_single_fetch();
        ram[8'h10] = 16'hBEEF;
        drive(1, 16'h0010, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({if_gnt, ls_gnt, mem_enable, mem_addr} !== {3'b101, 16'h0010}) begin
            failures++; $display("FAIL fetch_grant got=%b%b%b %h exp=101 0010",
                                 if_gnt, ls_gnt, mem_enable, mem_addr);
        end
        tick();
        checks++;
        if ({if_rsp_valid, ls_rsp_valid, if_rsp_data} !== {2'b10, 16'hBEEF}) begin
            failures++; $display("FAIL fetch_rsp got=%b%b %h exp=10 beef",
                                 if_rsp_valid, ls_rsp_valid, if_rsp_data);
        end
    endtask

    task automatic test_store_load();
        drive(0, 0, 1, 1, 16'h0040, 16'h1234, 0, 0, 0);
        checks++;
        if ({ls_gnt, mem_wr, mem_data_in} !== {2'b11, 16'h1234}) begin
            failures++; $display("FAIL store_grant got=%b%b %h exp=11 1234",
                                 ls_gnt, mem_wr, mem_data_in);
        end
        tick();
        checks++;
        if ({ls_rsp_valid, ls_wr_done, ls_rsp_data} !== {2'b11, 16'h0000}) begin
            failures++; $display("FAIL store_rsp got=%b%b %h exp=11 0000",
                                 ls_rsp_valid, ls_wr_done, ls_rsp_data);
        end
        drive(0, 0, 1, 0, 16'h0040, 16'hFFFF, 0, 0, 0); tick();
        checks++;
        if ({ls_rsp_valid, ls_wr_done, ls_rsp_data} !== {2'b10, 16'h1234}) begin
            failures++; $display("FAIL load_after_store got=%b%b %h exp=10 1234",
                                 ls_rsp_valid, ls_wr_done, ls_rsp_data);
        end
    endtask

    task automatic test_starvation();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        for (int k = 0; k < 6; k++) begin
            drive(1, 16'h0020, 1, 0, 16'h0030, 0, 0, 0, 0);
            checks++;
            if ({if_gnt, ls_gnt} !== ((k == LIM) ? 2'b10 : 2'b01)) begin
                failures++; $display("FAIL starve_cycle%0d got=%b%b exp=%b", k, if_gnt, ls_gnt,
                                     (k == LIM) ? 2'b10 : 2'b01);
            end
            tick();
            checks++;
            if ({if_rsp_valid, ls_rsp_valid} !== ((k == LIM) ? 2'b10 : 2'b01)) begin
                failures++; $display("FAIL starve_rsp%0d got=%b%b", k, if_rsp_valid, ls_rsp_valid);
            end
        end
    endtask

    task automatic test_errors();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
        drive(0, 0, 1, 1, 16'h0101, 16'hAAAA, 1, 0, 0); tick();
        checks++;
        if ({ls_rsp_err, ls_wr_done, err_sticky, err_addr} !== {3'b101, 16'h0101}) begin
            failures++; $display("FAIL ls_fault got=%b%b%b %h exp=101 0101",
                                 ls_rsp_err, ls_wr_done, err_sticky, err_addr);
        end
        drive(1, 16'h0203, 0, 0, 0, 0, 1, 0, 0); tick();
        checks++;
        if ({if_rsp_err, err_sticky, err_addr} !== {2'b11, 16'h0101}) begin
            failures++; $display("FAIL second_fault got=%b%b %h exp=11 0101",
                                 if_rsp_err, err_sticky, err_addr);
        end
        drive(0, 0, 1, 0, 16'h0305, 0, 1, 1, 0); tick();
        checks++;
        if ({err_sticky, err_addr} !== {1'b1, 16'h0305}) begin
            failures++; $display("FAIL clr_with_fault got=%b %h exp=1 0305", err_sticky, err_addr);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
        checks++;
        if ({err_sticky, err_addr} !== 17'h0) begin
            failures++; $display("FAIL clr_only got=%b %h exp=0 0000", err_sticky, err_addr);
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 16'h0050, 1, 0, 16'h0060, 0, 0, 0, 0); tick();
        drive(1, 16'h0050, 1, 0, 16'h0060, 0, 0, 0, 0); tick();
        drive(1, 16'h0050, 1, 0, 16'h0060, 0, 0, 0, 1);
        checks++;
        if ({if_gnt, ls_gnt, mem_enable} !== 3'b011) begin
            failures++; $display("FAIL gnt_in_reset got=%b%b%b exp=011", if_gnt, ls_gnt, mem_enable);
        end
        tick();
        checks++;
        if ({if_rsp_valid, ls_rsp_valid, ls_rsp_data} !== 18'h0) begin
            failures++; $display("FAIL rsp_after_reset got=%b%b %h exp=00 0000",
                                 if_rsp_valid, ls_rsp_valid, ls_rsp_data);
        end
        // Starvation count restarts from zero: ls wins LIM more conflicts.
        for (int k = 0; k <= LIM; k++) begin
            drive(1, 16'h0050, 1, 0, 16'h0060, 0, 0, 0, 0);
            checks++;
            if ({if_gnt, ls_gnt} !== ((k == LIM) ? 2'b10 : 2'b01)) begin
                failures++; $display("FAIL post_reset_arb%0d got=%b%b", k, if_gnt, ls_gnt);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic        p_if, p_ls, p_lw;
        logic [15:0] p_ia, p_la, p_wd;
        p_if = 0; p_ls = 0; p_lw = 0; p_ia = 0; p_la = 0; p_wd = 0;
        for (int n = 0; n < 400; n++) begin
            if (!p_if && $urandom_range(0, 2) != 0) begin
                p_if = 1; p_ia = 16'($urandom);
            end
            if (!p_ls && $urandom_range(0, 2) != 0) begin
                p_ls = 1; p_lw = 1'($urandom); p_la = 16'($urandom); p_wd = 16'($urandom);
            end
            drive(p_if, p_ia, p_ls, p_lw, p_la, p_wd, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
            checks++;
            if (dgnt !== mgnt()) begin
                failures++; $display("FAIL rand_grant n=%0d got=%h exp=%h", n, dgnt, mgnt());
            end
            if (eg_if) p_if = 0;
            if (eg_ls) p_ls = 0;
            tick();
            checks++;
            if (dvec !== mvec()) begin
                failures++; $display("FAIL rand_regs n=%0d got=%h exp=%h", n, dvec, mvec());
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);
        lost = 0; eg_if = 0; eg_ls = 0;
        {m_if_valid, m_if_err, m_ls_valid, m_ls_err, m_wr_done, m_sticky} = '0;
        m_if_data = '0; m_ls_data = '0; m_eaddr = '0;
        rst = 1; if_req = 0; ls_req = 0; ls_wr = 0; mem_err = 0; err_clr = 0;
        if_addr = 0; ls_addr = 0; ls_wdata = 0;

        test_reset();
        test_single_fetch();
        test_store_load();
        test_starvation();
        test_errors();
        test_reset_mid();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
